// File: rtl/d_cache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with an uncached window at 0xbfaf_xxxx.
// Hit/miss counters exist only when DCACHE_PERF_CNT_EN is defined; otherwise both outputs are tied to 0.
module d_cache_2way #(
  parameter int A_WIDTH  = 32,
  parameter int C_INDEX  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  output logic [31:0]        p_din,
  input  logic               p_strobe,
  input  logic               p_rw,
  input  logic [3:0]         p_wen,
  input  logic [1:0]         p_size,
  output logic               p_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  input  logic [31:0]        m_dout,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  input  logic               m_ready,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);
  localparam int TAG_W   = A_WIDTH - C_INDEX - OFFSET_W - 2;
  localparam int SETS    = 1 << C_INDEX;
  localparam int TAG_LSB = C_INDEX + OFFSET_W + 2;
  localparam int WA_W    = C_INDEX + OFFSET_W;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_e;
  state_e state_q, state_d;

  logic [TAG_W-1:0]    tag;
  logic [C_INDEX-1:0]  idx;
  logic [OFFSET_W-1:0] woff;
  logic [1:0]          unused_bits;
  assign tag         = p_a[A_WIDTH-1:TAG_LSB];
  assign idx         = p_a[TAG_LSB-1:OFFSET_W+2];
  assign woff        = p_a[OFFSET_W+1:2];
  assign unused_bits = p_a[1:0];

  logic [1:0][SETS-1:0] valid_q, dirty_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [31:0]          data_q [2][1<<WA_W];
  logic [OFFSET_W-1:0]  beat_q, beat_d;
  logic                 victim_q;

  logic [1:0] hit_w;
  logic       hit, hit_way, uncached, hit_done, miss, victim_sel, last_beat;

  assign hit_w[0]   = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit_w[1]   = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit        = |hit_w;
  assign hit_way    = hit_w[1];
  assign uncached   = (p_a[31:16] == 16'hbfaf);
  assign hit_done   = (state_q == IDLE) && !rst && p_strobe && !uncached && hit;
  assign miss       = (state_q == IDLE) && !rst && p_strobe && !uncached && !hit;
  assign victim_sel = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign last_beat  = m_ready && (beat_q == {OFFSET_W{1'b1}});
  assign beat_d     = ((state_q != IDLE) && m_ready) ? beat_q + OFFSET_W'(1) : beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WB : REFILL;
      WB:      if (last_beat) state_d = REFILL;
      REFILL:  if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_din    = data_q[hit_way][{idx, woff}];
    p_ready  = 1'b0;
    m_a      = '0;
    m_din    = '0;
    m_strobe = 1'b0;
    m_rw     = 1'b0;
    m_wen    = 4'b0000;
    m_size   = 2'b00;
    case (state_q)
      IDLE: begin
        if (uncached) begin
          m_a[31:0] = {16'h1faf, p_a[15:0]};
          m_din     = p_dout;
          m_strobe  = p_strobe;
          m_rw      = p_rw;
          m_wen     = p_wen;
          m_size    = p_size;
          p_din     = m_dout;
          p_ready   = m_ready;
        end else begin
          p_ready = p_strobe && hit;
        end
      end
      WB: begin
        m_a      = {tag_q[victim_q][idx], idx, beat_q, 2'b00};
        m_din    = data_q[victim_q][{idx, beat_q}];
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        m_wen    = 4'b1111;
        m_size   = 2'b10;
      end
      REFILL: begin
        m_a      = {tag, idx, beat_q, 2'b00};
        m_strobe = 1'b1;
        m_wen    = 4'b1111;
        m_size   = 2'b10;
      end
      default: ;
    endcase
    if (rst) begin
      p_ready  = 1'b0;
      m_strobe = 1'b0;
    end
  end

  // The victim loses valid as soon as refill starts overwriting it, so an aborted fill never hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
      beat_q   <= '0;
      victim_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      if (hit_done) begin
        lru_q[idx] <= ~hit_way;
        if (p_rw) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (miss) begin
        victim_q <= victim_sel;
        if (!(valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]))
          valid_q[victim_sel][idx] <= 1'b0;
      end
      if (state_q == WB && last_beat) valid_q[victim_q][idx] <= 1'b0;
      if (state_q == REFILL && last_beat) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == REFILL && m_ready) begin
      data_q[victim_q][{idx, beat_q}] <= m_dout;
      if (last_beat) tag_q[victim_q][idx] <= tag;
    end
    if (hit_done && p_rw)
      for (int b = 0; b < 4; b++)
        if (p_wen[b]) data_q[hit_way][{idx, woff}][8*b +: 8] <= p_dout[8*b +: 8];
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_done) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss)     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_d_cache_2way.sv
// Directed bench for d_cache_2way: refill, write-hit merge, dirty eviction, bypass window, reset mid-refill.
module tb_d_cache_2way;
`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] p_a, p_dout, p_din, m_a, m_din, m_dout, hit_cnt, miss_cnt;
  logic        p_strobe, p_rw, p_ready, m_strobe, m_rw, m_ready;
  logic [3:0]  p_wen, m_wen;
  logic [1:0]  p_size, m_size;

  d_cache_2way dut (
    .clk(clk), .rst(rst), .p_a(p_a), .p_dout(p_dout), .p_din(p_din), .p_strobe(p_strobe),
    .p_rw(p_rw), .p_wen(p_wen), .p_size(p_size), .p_ready(p_ready), .m_a(m_a), .m_din(m_din),
    .m_dout(m_dout), .m_strobe(m_strobe), .m_rw(m_rw), .m_wen(m_wen), .m_size(m_size),
    .m_ready(m_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0, errors = 0, n_hit = 0, n_miss = 0;
  logic mem_en;

  typedef struct {logic [31:0] a; logic rw; logic [31:0] d;} beat_t;
  beat_t log_q[$];
  logic [31:0] mem [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hDEAD0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Single-cycle memory: a strobe seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (m_strobe && mem_en) begin
      m_ready = 1'b1;
      if (m_rw) mem[m_a] = merge(memrd(m_a), m_din, m_wen);
      m_dout = memrd(m_a);
      log_q.push_back('{m_a, m_rw, m_rw ? m_din : m_dout});
    end else begin
      m_ready = 1'b0;
    end
  end

  task automatic cpu_access(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                            input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    p_a = a; p_rw = rw; p_wen = wen; p_dout = wd; p_size = 2'b10; p_strobe = 1'b1;
    cyc = 0; rd = 32'hxxxxxxxx;
    while (1) begin
      @(negedge clk); #1; cyc++;
      if (p_ready) begin rd = p_din; break; end
      if (cyc > 100) begin
        checks++; errors++;
        $display("FAIL timeout addr %h: no p_ready within 100 cycles", a);
        break;
      end
    end
    @(posedge clk); #1;
    p_strobe = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; p_strobe = 1'b1; p_a = 32'hbfaf0000; p_rw = 1'b0; mem_en = 1'b1;
    @(negedge clk); #1;
    checks++; if (m_strobe !== 1'b0) begin errors++; $display("FAIL reset_m_strobe got %b exp 0", m_strobe); end
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL reset_p_ready got %b exp 0", p_ready); end
    checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL reset_hit_cnt got %0d exp 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_miss_cnt got %0d exp 0", miss_cnt); end
    @(posedge clk); #1;
    rst = 1'b0; p_strobe = 1'b0;
    @(negedge clk); #1;
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL idle_p_ready got %b exp 0", p_ready); end
    @(posedge clk); #1;
    log_q.delete();
  endtask

  task automatic test_refill;
    logic [31:0] rd; int cyc;
    cpu_access(32'h100, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_miss++; n_hit++;
    checks++; if (rd !== 32'hDEAD0100) begin errors++; $display("FAIL refill_data got %h exp DEAD0100", rd); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL refill_latency got %0d exp 6", cyc); end
    checks++;
    if (log_q.size() !== 4) begin errors++; $display("FAIL refill_beats got %0d exp 4", log_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q[i].a !== 32'h100 + 4*i || log_q[i].rw !== 1'b0) begin
        errors++; $display("FAIL refill_beat%0d got %h/%b exp %h/0", i, log_q[i].a, log_q[i].rw, 32'h100 + 4*i);
      end
    end
    checks++; if (miss_cnt !== (PERF ? n_miss : 0)) begin errors++; $display("FAIL miss_cnt got %0d exp %0d", miss_cnt, PERF ? n_miss : 0); end
    checks++; if (hit_cnt !== (PERF ? n_hit : 0)) begin errors++; $display("FAIL hit_cnt got %0d exp %0d", hit_cnt, PERF ? n_hit : 0); end
    log_q.delete();
  endtask

  task automatic test_write_hit;
    logic [31:0] rd; int cyc;
    cpu_access(32'h104, 1'b1, 4'b0101, 32'hAABBCCDD, rd, cyc);
    n_hit++;
    checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_hit_latency got %0d exp 1", cyc); end
    cpu_access(32'h104, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_hit++;
    checks++; if (rd !== 32'hDEBB01DD) begin errors++; $display("FAIL wr_merge got %h exp DEBB01DD", rd); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rd_hit_latency got %0d exp 1", cyc); end
    cpu_access(32'h10C, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_hit++;
    checks++; if (rd !== 32'hDEAD010C) begin errors++; $display("FAIL rd_word3 got %h exp DEAD010C", rd); end
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL hit_mem_traffic got %0d beats exp 0", log_q.size()); end
    checks++; if (hit_cnt !== (PERF ? n_hit : 0)) begin errors++; $display("FAIL hit_cnt_wr got %0d exp %0d", hit_cnt, PERF ? n_hit : 0); end
    log_q.delete();
  endtask

  task automatic test_evict;
    logic [31:0] rd, ea, ed; int cyc;
    cpu_access(32'h1040, 1'b0, 4'h0, 32'h0, rd, cyc);          // way0
    cpu_access(32'h2040, 1'b0, 4'h0, 32'h0, rd, cyc);          // way1
    cpu_access(32'h1040, 1'b1, 4'hF, 32'h11223344, rd, cyc);   // dirty way0
    cpu_access(32'h2040, 1'b0, 4'h0, 32'h0, rd, cyc);          // way0 becomes LRU
    n_miss += 2; n_hit += 4;
    log_q.delete();
    cpu_access(32'h3040, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_miss++; n_hit++;
    checks++; if (rd !== 32'hDEAD3040) begin errors++; $display("FAIL evict_data got %h exp DEAD3040", rd); end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL dirty_latency got %0d exp 10", cyc); end
    checks++;
    if (log_q.size() !== 8) begin errors++; $display("FAIL evict_beats got %0d exp 8", log_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      ea = (i < 4) ? 32'h1040 + 4*i : 32'h3040 + 4*(i-4);
      ed = (i == 0) ? 32'h11223344 : ea ^ 32'hDEAD0000;
      checks++;
      if (log_q[i].a !== ea || log_q[i].rw !== (i < 4) || log_q[i].d !== ed) begin
        errors++; $display("FAIL evict_beat%0d got %h/%b/%h exp %h/%b/%h", i, log_q[i].a, log_q[i].rw, log_q[i].d, ea, i < 4, ed);
      end
    end
    log_q.delete();
    cpu_access(32'h2040, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_hit++;
    checks++; if (cyc !== 1 || rd !== 32'hDEAD2040) begin errors++; $display("FAIL way1_kept got %h/%0d exp DEAD2040/1", rd, cyc); end
    cpu_access(32'h1040, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_miss++; n_hit++;
    checks++; if (cyc !== 6 || rd !== 32'h11223344) begin errors++; $display("FAIL wb_refetch got %h/%0d exp 11223344/6", rd, cyc); end
    checks++; if (miss_cnt !== (PERF ? n_miss : 0)) begin errors++; $display("FAIL miss_cnt_evict got %0d exp %0d", miss_cnt, PERF ? n_miss : 0); end
    log_q.delete();
  endtask

  task automatic test_bypass;
    logic [31:0] rd; int cyc;
    mem_en = 1'b0;
    p_a = 32'hbfaf0010; p_rw = 1'b1; p_wen = 4'b0001; p_dout = 32'h000000AB; p_size = 2'b00; p_strobe = 1'b1;
    @(negedge clk); #1;
    checks++; if (m_strobe !== 1'b1 || m_a !== 32'h1faf0010) begin errors++; $display("FAIL byp_addr got %b/%h exp 1/1faf0010", m_strobe, m_a); end
    checks++; if (m_wen !== 4'b0001 || m_rw !== 1'b1 || m_size !== 2'b00) begin errors++; $display("FAIL byp_ctrl got %b/%b/%b exp 0001/1/00", m_wen, m_rw, m_size); end
    checks++; if (m_din !== 32'h000000AB) begin errors++; $display("FAIL byp_din got %h exp 000000AB", m_din); end
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL byp_wait got %b exp 0", p_ready); end
    mem_en = 1'b1;
    @(negedge clk); #1;
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got %b exp 1", p_ready); end
    @(posedge clk); #1;
    p_strobe = 1'b0;
    checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL byp_beats got %0d exp 1", log_q.size()); end
    cpu_access(32'hbfaf0020, 1'b0, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'hC1020020 || cyc !== 1) begin errors++; $display("FAIL byp_read got %h/%0d exp C1020020/1", rd, cyc); end
    checks++; if (hit_cnt !== (PERF ? n_hit : 0) || miss_cnt !== (PERF ? n_miss : 0)) begin
      errors++; $display("FAIL byp_counters got %0d/%0d exp %0d/%0d", hit_cnt, miss_cnt, PERF ? n_hit : 0, PERF ? n_miss : 0);
    end
    log_q.delete();
  endtask

  task automatic test_reset_mid_refill;
    logic [31:0] rd; int cyc;
    p_a = 32'h5000; p_rw = 1'b0; p_wen = 4'h0; p_size = 2'b10; p_strobe = 1'b1;
    cyc = 0;
    while (log_q.size() < 3 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    checks++; if (log_q.size() !== 3) begin errors++; $display("FAIL mid_refill_reach got %0d beats exp 3", log_q.size()); end
    rst = 1'b1; p_strobe = 1'b0;
    #1;
    checks++; if (m_strobe !== 1'b0 || p_ready !== 1'b0) begin errors++; $display("FAIL rst_abort got %b/%b exp 0/0", m_strobe, p_ready); end
    @(posedge clk); #1;
    rst = 1'b0; n_hit = 0; n_miss = 0;
    @(negedge clk); #1;
    checks++; if (m_strobe !== 1'b0) begin errors++; $display("FAIL rst_idle_strobe got %b exp 0", m_strobe); end
    @(posedge clk); #1;
    log_q.delete();
    cpu_access(32'h5000, 1'b0, 4'h0, 32'h0, rd, cyc);
    n_miss++; n_hit++;
    checks++; if (rd !== 32'hDEAD5000 || cyc !== 6) begin errors++; $display("FAIL rerefill got %h/%0d exp DEAD5000/6", rd, cyc); end
    checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL rerefill_beats got %0d exp 4", log_q.size()); end
    checks++; if (miss_cnt !== (PERF ? n_miss : 0)) begin errors++; $display("FAIL rerefill_miss_cnt got %0d exp %0d", miss_cnt, PERF ? n_miss : 0); end
    log_q.delete();
  endtask

  initial begin
    rst = 1'b1; p_a = '0; p_dout = '0; p_strobe = 1'b0; p_rw = 1'b0; p_wen = '0; p_size = '0;
    m_dout = '0; m_ready = 1'b0; mem_en = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_refill;
    test_write_hit;
    test_evict;
    test_bypass;
    test_reset_mid_refill;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/d_cache_2way.md
D_CACHE_2WAY -- requirements
Module: d_cache_2way

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32: address width.
REQ-002 SHALL have parameter C_INDEX, default 6: set-index bits (2^C_INDEX sets).
REQ-003 SHALL have parameter OFFSET_W, default 2: word-offset bits (LINE_WORDS = 2^OFFSET_W words per line); tag width = A_WIDTH-C_INDEX-OFFSET_W-2.
REQ-004 SHALL have ports:
- clk, input, 1: single clock, all state rising-edge.
- rst, input, 1: reset, asynchronous and active-high.
- p_a, input, A_WIDTH: CPU byte address.
- p_dout, input, 32: CPU write data.
- p_din, output, 32: CPU read data.
- p_strobe, input, 1: CPU request valid.
- p_rw, input, 1: 0 read, 1 write.
- p_wen, input, 4: byte enables; bit3 = byte [31:24].
- p_size, input, 2: access size, forwarded on bypass.
- p_ready, output, 1: request complete this cycle.
- m_a, output, A_WIDTH: memory address.
- m_din, output, 32: memory write data.
- m_dout, input, 32: memory read data.
- m_strobe, output, 1: memory request valid.
- m_rw, output, 1: memory write.
- m_wen, output, 4: memory byte enables.
- m_size, output, 2: memory size.
- m_ready, input, 1: memory beat complete.
- hit_cnt, output, 32: hit counter.
- miss_cnt, output, 32: miss counter.

Function
REQ-005 SHALL be 2-way set-associative, write-back, write-allocate, with per-way valid/dirty/tag and one LRU bit per set.
REQ-006 SHALL treat p_a[31:16]==16'hbfaf as uncached: m_a={16'h1faf,p_a[15:0]}; m_din/m_strobe/m_rw/m_wen/m_size pass p_*; p_din=m_dout; p_ready=m_ready; no cache state changes.
REQ-007 SHALL assert p_ready combinationally in IDLE on a cached hit; a read returns the addressed word; a write merges p_dout per p_wen bit (any pattern), sets dirty at the clock edge.
REQ-008 SHALL set LRU of the set to the non-accessed way on every hit.
REQ-009 SHALL choose the victim as: invalid way0, else invalid way1, else the LRU way.
REQ-010 SHALL use FSM IDLE->WB (victim valid and dirty) or IDLE->REFILL (otherwise); WB->REFILL after the last beat; REFILL->IDLE after the last beat; the request then hits in IDLE.
REQ-011 SHALL issue WB and REFILL as LINE_WORDS single-word beats, word 0 first, m_wen=4'b1111, m_size=2'b10, m_strobe held until m_ready, beat counter advanced on m_ready.
REQ-012 SHALL write each refill word on its m_ready beat, and set valid=1, dirty=0, tag at the final beat only.
REQ-013 SHALL have clean-miss latency LINE_WORDS memory beats + 1 cycle; dirty-miss latency 2*LINE_WORDS beats + 1.
REQ-014 SHALL require the CPU to hold p_a/p_rw/p_wen/p_dout stable until p_ready; a deasserted p_strobe mid-miss does not abort the line fill.
REQ-015 SHALL hold p_ready=0 and ignore new requests outside IDLE.

Reset
REQ-016 SHALL on rst clear all valid, dirty and LRU bits, set state IDLE, beat counter 0, counters 0; tag/data arrays are not reset.
REQ-017 SHALL abandon any WB/REFILL in progress on rst; a partially filled line stays invalid.
REQ-018 SHALL drive m_strobe=0 and p_ready=0 while rst is high.

Configuration
REQ-019 SHALL, with DCACHE_PERF_CNT_EN defined, increment hit_cnt once per cached hit completion and miss_cnt once per IDLE->WB/REFILL transition, both wrapping at 2^32.
REQ-020 SHALL, without DCACHE_PERF_CNT_EN, tie hit_cnt and miss_cnt to 0 and instantiate no counter registers.

Verification
REQ-021 Read 0x0000_0100 after reset -> 4 refill beats at 0x100/0x104/0x108/0x10C, then p_ready with word 0 data; miss_cnt=1.
REQ-022 Write 0xAABBCCDD p_wen=4'b0101 to 0x104 hit, then read 0x104 -> byte lanes 2 and 0 updated, others preserved, no memory traffic.
REQ-023 Fill both ways of set 4 (0x1040, 0x2040), dirty way0, touch 0x2040, miss at 0x3040 -> way0 written back to 0x1040..0x104C before refill from 0x3040.
REQ-024 Access 0xbfaf_0010 write, p_wen=4'b0001 -> m_a=0x1faf_0010, m_wen=4'b0001, p_ready follows m_ready, hit/miss counters unchanged.
REQ-025 Assert rst during beat 2 of a refill -> state IDLE, m_strobe=0; re-read same address misses again with 4 beats.
